// File: rtl/dffre_arb_pkg.sv
// Shared types and helpers for the dffre register-bank arbiter.
package dffre_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } arb_state_t;

    // Index width that never collapses to zero bits for tiny parameter values.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dffre_word.sv
// One register word: synchronous clear (highest priority), then enable-gated load.
module dffre_word #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_Reset,
    input  logic              i_Enable,
    input  logic [DATA_W-1:0] i_D,
    output logic [DATA_W-1:0] o_Q
);

    always_ff @(posedge clk) begin
        if (i_Reset) begin
            o_Q <= '0;
        end else if (i_Enable) begin
            o_Q <= i_D;
        end
    end

endmodule

// File: rtl/dffre_bank_arbiter.sv
// Arbitrates NUM_REQ word writers onto a bank of NUM_REGS dffre words, plus bank-wide clear.
// Define DFFRE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module dffre_bank_arbiter
    import dffre_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 6,
    localparam int ADDR_W  = clog2_min1(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       i_Reset,
    input  logic [NUM_REQ-1:0]         i_Req_Valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  i_Req_Addr,
    input  logic [NUM_REQ*DATA_W-1:0]  i_Req_Data,
    output logic [NUM_REQ-1:0]         o_Req_Ready,
    input  logic                       i_Clear,
    output logic                       o_Clear_Done,
    output logic                       o_Err,
    output logic                       o_Busy,
    output logic [NUM_REGS*DATA_W-1:0] o_Q
);

    localparam int REQ_W = clog2_min1(NUM_REQ);
    localparam logic [ADDR_W:0]  NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [REQ_W-1:0] LAST_REQ   = REQ_W'(NUM_REQ - 1);

    arb_state_t          state, next_state;
    logic [REQ_W-1:0]    search_base;
    logic                grant_found;
    logic [REQ_W-1:0]    grant_idx;
    logic [ADDR_W-1:0]   grant_addr;
    logic [DATA_W-1:0]   grant_data;
    logic [REQ_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                bad_addr;
    logic                word_rst;
    logic [NUM_REGS-1:0] word_en;

`ifdef DFFRE_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [REQ_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (i_Reset) begin
            rr_ptr <= '0;
        end else if (state == WRITE) begin
            rr_ptr <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
        end
    end

    assign search_base = rr_ptr;
`endif

    // Rotating search as two passes: indices at/after the base first, then the wrap-around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        grant_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && i_Req_Valid[i] && (REQ_W'(i) >= search_base)) begin
                grant_found = 1'b1;
                grant_idx   = REQ_W'(i);
                grant_addr  = i_Req_Addr[i*ADDR_W +: ADDR_W];
                grant_data  = i_Req_Data[i*DATA_W +: DATA_W];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && i_Req_Valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = REQ_W'(i);
                grant_addr  = i_Req_Addr[i*ADDR_W +: ADDR_W];
                grant_data  = i_Req_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (i_Reset) begin
            win_idx  <= '0;
            win_addr <= '0;
            win_data <= '0;
        end else if (state == IDLE && !i_Clear && grant_found) begin
            win_idx  <= grant_idx;
            win_addr <= grant_addr;
            win_data <= grant_data;
        end
    end

    // Outputs are gated by i_Reset so a reset landing on a WRITE cycle yields no ready pulse.
    always_comb begin
        next_state   = state;
        o_Req_Ready  = '0;
        o_Err        = 1'b0;
        o_Clear_Done = 1'b0;
        word_rst     = i_Reset;
        word_en      = '0;
        bad_addr     = ({1'b0, win_addr} >= NUM_REGS_X);
        unique case (state)
            IDLE: begin
                if (i_Clear) begin
                    next_state = CLEAR;
                end else if (grant_found) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = IDLE;
                if (!i_Reset) begin
                    o_Req_Ready[win_idx] = 1'b1;
                    o_Err                = bad_addr;
                    for (int unsigned w = 0; w < NUM_REGS; w++) begin
                        word_en[w] = !bad_addr && (win_addr == ADDR_W'(w));
                    end
                end
            end
            CLEAR: begin
                next_state   = IDLE;
                word_rst     = 1'b1;
                o_Clear_Done = !i_Reset;
            end
            default: next_state = IDLE;
        endcase
    end

    assign o_Busy = (state != IDLE);

    for (genvar w = 0; w < NUM_REGS; w++) begin : g_word
        dffre_word #(
            .DATA_W(DATA_W)
        ) u_word (
            .clk     (clk),
            .i_Reset (word_rst),
            .i_Enable(word_en[w]),
            .i_D     (win_data),
            .o_Q     (o_Q[w*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_dffre_bank_arbiter.sv
// Self-checking bench: transaction-level bank model plus directed and random stimulus.
module tb_dffre_bank_arbiter;

    localparam int NQ = 4;
    localparam int DW = 8;
    localparam int NR = 6;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_Reset;
    logic [NQ-1:0]     i_Req_Valid;
    logic [NQ*AW-1:0]  i_Req_Addr;
    logic [NQ*DW-1:0]  i_Req_Data;
    logic [NQ-1:0]     o_Req_Ready;
    logic              i_Clear;
    logic              o_Clear_Done;
    logic              o_Err;
    logic              o_Busy;
    logic [NR*DW-1:0]  o_Q;

    dffre_bank_arbiter #(
        .NUM_REQ (NQ),
        .DATA_W  (DW),
        .NUM_REGS(NR)
    ) dut (
        .clk         (clk),
        .i_Reset     (i_Reset),
        .i_Req_Valid (i_Req_Valid),
        .i_Req_Addr  (i_Req_Addr),
        .i_Req_Data  (i_Req_Data),
        .o_Req_Ready (o_Req_Ready),
        .i_Clear     (i_Clear),
        .o_Clear_Done(o_Clear_Done),
        .o_Err       (o_Err),
        .o_Busy      (o_Busy),
        .o_Q         (o_Q)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bank contents, pointer, and the one pending transaction (0 none, 1 write, 2 clear).
    logic [DW-1:0] mem [NR];
    int            m_ptr  = 0;
    int            m_act  = 0;
    int            m_k    = 0;
    int            m_addr = 0;
    logic [DW-1:0] m_data = '0;
    bit            granted [NQ];
    int            glog [$];
    bit            cmp_en = 1'b0;
    int            c_idx;

    always @(posedge clk) begin
        if (i_Reset) begin
            for (int i = 0; i < NR; i++) mem[i] = '0;
            m_ptr = 0;
            m_act = 0;
        end else if (m_act == 1) begin
            if (m_addr < NR) mem[m_addr] = m_data;
            granted[m_k] = 1'b1;
            m_ptr = (m_k + 1) % NQ;
            m_act = 0;
        end else if (m_act == 2) begin
            for (int i = 0; i < NR; i++) mem[i] = '0;
            m_act = 0;
        end else if (i_Clear) begin
            m_act = 2;
        end else begin
            for (int i = 0; i < NQ; i++) begin
`ifdef DFFRE_ARB_FIXED_PRIO_EN
                c_idx = i;
`else
                c_idx = (m_ptr + i) % NQ;
`endif
                if (m_act == 0 && i_Req_Valid[c_idx]) begin
                    m_act  = 1;
                    m_k    = c_idx;
                    m_addr = int'(i_Req_Addr[c_idx*AW +: AW]);
                    m_data = i_Req_Data[c_idx*DW +: DW];
                end
            end
        end
    end

    logic [NQ-1:0]    exp_rdy;
    logic [NR*DW-1:0] exp_q;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_rdy = '0;
            if (m_act == 1 && !i_Reset) exp_rdy[m_k] = 1'b1;
            for (int w = 0; w < NR; w++) exp_q[w*DW +: DW] = mem[w];
            chk("ready", 64'(o_Req_Ready), 64'(exp_rdy));
            chk("err", 64'(o_Err), 64'(m_act == 1 && !i_Reset && m_addr >= NR));
            chk("clear_done", 64'(o_Clear_Done), 64'(m_act == 2 && !i_Reset));
            chk("busy", 64'(o_Busy), 64'(m_act != 0));
            chk("bank", 64'(o_Q), 64'(exp_q));
            for (int k = 0; k < NQ; k++) if (o_Req_Ready[k]) glog.push_back(k);
        end
    end

    // mode 0: drop valid when granted; 1: hold valid, bump data; 2: random traffic
    int mode = 0;

    task automatic step();
        @(posedge clk);
        #2;
        for (int k = 0; k < NQ; k++) begin
            if (granted[k]) begin
                granted[k] = 1'b0;
                if (mode == 1) i_Req_Data[k*DW +: DW] = i_Req_Data[k*DW +: DW] + 8'd1;
                else           i_Req_Valid[k] = 1'b0;
            end
        end
        if (mode == 2) begin
            for (int k = 0; k < NQ; k++) begin
                if (!i_Req_Valid[k]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        i_Req_Valid[k]          = 1'b1;
                        i_Req_Addr[k*AW +: AW]  = AW'($urandom_range(0, 7));
                        i_Req_Data[k*DW +: DW]  = DW'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    i_Req_Valid[k] = 1'b0;
                end
            end
            i_Clear = ($urandom_range(0, 24) == 0);
            i_Reset = ($urandom_range(0, 149) == 0);
        end
    endtask

    task automatic do_reset();
        i_Reset     = 1'b1;
        i_Clear     = 1'b0;
        i_Req_Valid = '0;
        step();
        step();
        i_Reset = 1'b0;
    endtask

    task automatic set_req(input int k, input int addr, input int data);
        i_Req_Valid[k]         = 1'b1;
        i_Req_Addr[k*AW +: AW] = AW'(addr);
        i_Req_Data[k*DW +: DW] = DW'(data);
    endtask

    int exp4 [4];

    initial begin
        i_Reset     = 1'b1;
        i_Clear     = 1'b0;
        i_Req_Valid = '0;
        i_Req_Addr  = '0;
        i_Req_Data  = '0;
        step();
        step();
        cmp_en  = 1'b1;
        i_Reset = 1'b0;

        // 1: reset after random traffic
        mode = 2;
        repeat (100) step();
        mode        = 0;
        i_Reset     = 1'b1;
        i_Clear     = 1'b0;
        i_Req_Valid = '0;
        step();
        @(negedge clk);
        chk("reset_ready", 64'(o_Req_Ready), 64'(0));
        step();
        i_Reset = 1'b0;
        @(negedge clk);
        chk("reset_bank", 64'(o_Q), 64'(0));
        chk("reset_busy", 64'(o_Busy), 64'(0));

        // 2: single write, req1 -> word3
        set_req(1, 3, 8'hA5);
        step();
        @(negedge clk);
        chk("single_ready", 64'(o_Req_Ready), 64'(4'b0010));
        step();
        @(negedge clk);
        chk("single_word3", 64'(o_Q[3*DW +: DW]), 64'(8'hA5));

        // 3: four-way contention from pointer 0
        do_reset();
        glog.delete();
        for (int k = 0; k < NQ; k++) set_req(k, k, 8'h10 + k);
        for (int c = 0; c < 40 && glog.size() < 4; c++) step();
        chk("contention_count", 64'(glog.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            chk("contention_order", 64'(i < glog.size() ? glog[i] : -1), 64'(i));
        @(negedge clk);
        for (int k = 0; k < NQ; k++)
            chk("contention_word", 64'(o_Q[k*DW +: DW]), 64'(8'h10 + k));

        // 4: fairness with req0 and req2 held valid
        do_reset();
        glog.delete();
        mode = 1;
        set_req(0, 4, 8'h40);
        set_req(2, 5, 8'h50);
`ifdef DFFRE_ARB_FIXED_PRIO_EN
        exp4 = '{0, 0, 0, 0};
`else
        exp4 = '{0, 2, 0, 2};
`endif
        for (int c = 0; c < 40 && glog.size() < 4; c++) step();
        chk("fair_count", 64'(glog.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++)
            chk("fair_order", 64'(i < glog.size() ? glog[i] : -1), 64'(exp4[i]));
        i_Req_Valid = '0;
        mode = 0;
        repeat (4) step();

        // 5: clear and write requested in the same idle cycle
        i_Clear = 1'b1;
        set_req(2, 2, 8'hC2);
        step();
        i_Clear = 1'b0;
        @(negedge clk);
        chk("clr_done", 64'(o_Clear_Done), 64'(1));
        chk("clr_no_ready", 64'(o_Req_Ready), 64'(0));
        step();
        @(negedge clk);
        chk("clr_bank", 64'(o_Q), 64'(0));
        step();
        @(negedge clk);
        chk("clr_then_ready", 64'(o_Req_Ready), 64'(4'b0100));
        step();
        @(negedge clk);
        chk("clr_then_word2", 64'(o_Q[2*DW +: DW]), 64'(8'hC2));

        // 6: out-of-range address, then reset landing on a write cycle
        set_req(3, 7, 8'h55);
        step();
        @(negedge clk);
        chk("bad_ready", 64'(o_Req_Ready), 64'(4'b1000));
        chk("bad_err", 64'(o_Err), 64'(1));
        step();
        @(negedge clk);
        chk("bad_word2_kept", 64'(o_Q[2*DW +: DW]), 64'(8'hC2));
        set_req(0, 1, 8'h77);
        step();
        i_Reset = 1'b1;
        @(negedge clk);
        chk("rst_write_ready", 64'(o_Req_Ready), 64'(0));
        step();
        i_Reset     = 1'b0;
        i_Req_Valid = '0;
        @(negedge clk);
        chk("rst_write_busy", 64'(o_Busy), 64'(0));
        chk("rst_write_bank", 64'(o_Q), 64'(0));

        // random soak
        mode = 2;
        repeat (2000) step();
        mode        = 0;
        i_Reset     = 1'b0;
        i_Clear     = 1'b0;
        i_Req_Valid = '0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
